// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM command arbiter.
// Contents:
//   CMD_*     5-bit SDRAM commands, encoded {CKE,CS_N,RAS_N,CAS_N,WE_N}
//   ADDR_A10  address with A10 set (selects all banks for PRECHARGE)
//   arb_state_e  arbiter state encoding
package sdram_pkg;

  localparam logic [4:0] CMD_NOP   = 5'b10111;
  localparam logic [4:0] CMD_ACT   = 5'b10011;
  localparam logic [4:0] CMD_READ  = 5'b10101;
  localparam logic [4:0] CMD_WRITE = 5'b10100;
  localparam logic [4:0] CMD_PREC  = 5'b10010;
  localparam logic [4:0] CMD_AREF  = 5'b10001;
  localparam logic [4:0] CMD_MRS   = 5'b10000;

  localparam logic [11:0] ADDR_A10 = 12'h400;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_REF_PRE,
    ST_REF_WAIT_P,
    ST_REF_AREF,
    ST_REF_WAIT_R
  } arb_state_e;

endpackage

// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the SDRAM command arbiter and its neighbours
// (init sequencer, write/read sequencers, SDRAM pins).
// Modports:
//   master - arbiter side: consumes init/write/read command sources,
//            drives start pulses, the pin bus, busy and ack_err
//   slave  - the opposite view, used by the sequencers / a test bench
interface sdram_arbiter_if;

  logic        init_done;
  logic [4:0]  init_cmd;
  logic [11:0] init_addr;

  logic        wr_req;
  logic        write_en;
  logic        write_ack;
  logic [4:0]  write_cmd;
  logic [11:0] write_addr;

  logic        rd_req;
  logic        read_en;
  logic        read_ack;
  logic [4:0]  read_cmd;
  logic [11:0] read_addr;

  logic [4:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic        busy;
  logic        ack_err;

  modport master (
    input  init_done, init_cmd, init_addr,
    input  wr_req, write_ack, write_cmd, write_addr,
    input  rd_req, read_ack, read_cmd, read_addr,
    output write_en, read_en, sdram_cmd, sdram_addr, busy, ack_err
  );

  modport slave (
    output init_done, init_cmd, init_addr,
    output wr_req, write_ack, write_cmd, write_addr,
    output rd_req, read_ack, read_cmd, read_addr,
    input  write_en, read_en, sdram_cmd, sdram_addr, busy, ack_err
  );

endinterface

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer.
// Ports:
//   S_CLK, RST_N  clock, asynchronous active-low reset
//   hold_i        keep the counter at zero (arbiter still in INIT)
//   clr_i         refresh has been issued; drop the pending request
//   ref_pend_o    a refresh is owed
// The counter runs 0..REF_PERIOD-1 and sets ref_pend on wrap. Missed
// refreshes are not accumulated, and a wrap coinciding with clr_i keeps
// the request pending.
module sdram_ref_timer #(
  parameter int unsigned REF_PERIOD = 780
) (
  input  logic S_CLK,
  input  logic RST_N,
  input  logic hold_i,
  input  logic clr_i,
  output logic ref_pend_o
);

  localparam int unsigned CW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

  logic [CW-1:0] ref_cnt_q, ref_cnt_d;
  logic          ref_pend_q, ref_pend_d;
  logic          wrap;

  always_comb begin
    wrap       = 1'b0;
    ref_cnt_d  = ref_cnt_q;
    ref_pend_d = ref_pend_q;
    if (hold_i) begin
      ref_cnt_d = '0;
    end else if (ref_cnt_q == CW'(REF_PERIOD - 1)) begin
      ref_cnt_d = '0;
      wrap      = 1'b1;
    end else begin
      ref_cnt_d = ref_cnt_q + CW'(1);
    end
    if (wrap) begin
      ref_pend_d = 1'b1;
    end else if (clr_i) begin
      ref_pend_d = 1'b0;
    end
  end

  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
    end else begin
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
    end
  end

  assign ref_pend_o = ref_pend_q;

endmodule

// File: rtl/sdram_arbiter.sv
// SDRAM command arbiter: sits between the init/write/read sequencers and
// the SDRAM pins, owns auto-refresh timing and the single command bus.
// Ports:
//   S_CLK, RST_N  clock, asynchronous active-low reset
//   bus           sdram_arbiter_if.master (init, write and read sources,
//                 write_en/read_en start pulses, sdram_cmd/sdram_addr,
//                 busy = not IDLE, sticky ack_err on ack timeout)
// Build option: define ARB_ROUND_ROBIN_EN to alternate write/read grants
// when both request together; otherwise write has fixed priority.
// Pin outputs are registered from the current state, so the bus shows the
// command chosen in the previous cycle (one cycle of pass-through latency).
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned REF_PERIOD  = 780,
  parameter int unsigned TRP         = 2,
  parameter int unsigned TRFC        = 7,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input logic             S_CLK,
  input logic             RST_N,
  sdram_arbiter_if.master bus
);

  // One counter serves the ack timeout and both refresh waits.
  localparam int unsigned CNT_MAX =
    (ACK_TIMEOUT > TRFC) ? ((ACK_TIMEOUT > TRP) ? ACK_TIMEOUT : TRP)
                         : ((TRFC > TRP) ? TRFC : TRP);
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [4:0]        cmd_q, cmd_d;
  logic [11:0]       addr_q, addr_d;
  logic              wen_q, wen_d;
  logic              ren_q, ren_d;
  logic              ack_err_q, ack_err_d;
  logic              ref_pend;
  logic              grant_wr, grant_rd;

  sdram_ref_timer #(
    .REF_PERIOD (REF_PERIOD)
  ) u_ref_timer (
    .S_CLK      (S_CLK),
    .RST_N      (RST_N),
    .hold_i     (state_q == ST_INIT),
    .clr_i      (state_q == ST_REF_AREF),
    .ref_pend_o (ref_pend)
  );

`ifdef ARB_ROUND_ROBIN_EN
  // 1 = the last grant went to the write sequencer; resets to "read".
  logic last_wr_q;

  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      last_wr_q <= 1'b0;
    end else if (wen_d) begin
      last_wr_q <= 1'b1;
    end else if (ren_d) begin
      last_wr_q <= 1'b0;
    end
  end

  assign grant_wr = bus.wr_req && (!bus.rd_req || !last_wr_q);
`else
  assign grant_wr = bus.wr_req;
`endif
  assign grant_rd = bus.rd_req && !grant_wr;

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    cmd_d     = CMD_NOP;
    addr_d    = ADDR_A10;
    wen_d     = 1'b0;
    ren_d     = 1'b0;
    ack_err_d = ack_err_q;
    unique case (state_q)
      ST_INIT: begin
        cmd_d  = bus.init_cmd;
        addr_d = bus.init_addr;
        if (bus.init_done) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (ref_pend) begin
          state_d = ST_REF_PRE;
        end else if (grant_wr) begin
          state_d = ST_WRITE;
          wen_d   = 1'b1;
        end else if (grant_rd) begin
          state_d = ST_READ;
          ren_d   = 1'b1;
        end
      end
      ST_WRITE: begin
        cmd_d  = bus.write_cmd;
        addr_d = bus.write_addr;
        if (bus.write_ack) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          state_d   = ST_IDLE;
          ack_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_READ: begin
        cmd_d  = bus.read_cmd;
        addr_d = bus.read_addr;
        if (bus.read_ack) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          state_d   = ST_IDLE;
          ack_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REF_PRE: begin
        cmd_d   = CMD_PREC;
        state_d = ST_REF_WAIT_P;
      end
      ST_REF_WAIT_P: begin
        if (cnt_q == CNT_W'(TRP - 1)) state_d = ST_REF_AREF;
        else                          cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_REF_AREF: begin
        cmd_d   = CMD_AREF;
        state_d = ST_REF_WAIT_R;
      end
      ST_REF_WAIT_R: begin
        if (cnt_q == CNT_W'(TRFC - 1)) state_d = ST_IDLE;
        else                           cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      cmd_q     <= CMD_NOP;
      addr_q    <= ADDR_A10;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
      ack_err_q <= ack_err_d;
    end
  end

  assign bus.write_en   = wen_q;
  assign bus.read_en    = ren_q;
  assign bus.sdram_cmd  = cmd_q;
  assign bus.sdram_addr = addr_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.ack_err    = ack_err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter (REF_PERIOD overridden to 20).
// Inputs change 1 time unit after each rising edge; outputs are checked at
// the same point. Cycle numbers below count edges after the edge on which
// the arbiter leaves INIT (t0).
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int unsigned RP = 20;

  logic S_CLK = 1'b0;
  logic RST_N = 1'b0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int          cyc   = 0;
  int          t0    = 0;
  int          ack_in = 0;
  logic        ack_w  = 1'b0;

  always #5 S_CLK = ~S_CLK;

  sdram_arbiter_if bus ();

  sdram_arbiter #(
    .REF_PERIOD (RP)
  ) dut (
    .S_CLK (S_CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  function automatic logic [4:0]  wpat (int c); return {2'b01, 3'(c)};        endfunction
  function automatic logic [11:0] waddr(int c); return 12'(c * 17 + 256);     endfunction
  function automatic logic [4:0]  rpat (int c); return {2'b00, 3'(c + 5)};    endfunction
  function automatic logic [11:0] raddr(int c); return 12'(c * 29 + 2048);    endfunction

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock; the sequencers' command/address change every cycle.
  task automatic tick();
    @(posedge S_CLK);
    #1;
    cyc++;
    bus.write_cmd  = wpat(cyc);
    bus.write_addr = waddr(cyc);
    bus.read_cmd   = rpat(cyc);
    bus.read_addr  = raddr(cyc);
  endtask

  task automatic clear_inputs();
    bus.wr_req    = 1'b0;
    bus.rd_req    = 1'b0;
    bus.write_ack = 1'b0;
    bus.read_ack  = 1'b0;
    bus.init_cmd  = CMD_NOP;
    bus.init_addr = ADDR_A10;
    ack_in        = 0;
  endtask

  // Reset, then leave INIT on the next edge; t0 marks that edge.
  task automatic restart();
    RST_N = 1'b0;
    clear_inputs();
    bus.init_done = 1'b0;
    tick();
    RST_N = 1'b1;
    bus.init_done = 1'b1;
    tick();
    t0 = cyc;
  endtask

  // Sequencer model: acknowledge a grant seen at cycle g during cycle g+1.
  task automatic svc_ack();
    bus.write_ack = 1'b0;
    bus.read_ack  = 1'b0;
    if (ack_in == 1) begin
      if (ack_w) bus.write_ack = 1'b1;
      else       bus.read_ack  = 1'b1;
    end
    if (ack_in > 0) ack_in--;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   rel;
    int   nw;
    int   nr;
    logic prev_w;
    logic have_prev;
    logic prev_busy;
    logic [4:0] exp_cmd;

    clear_inputs();
    bus.init_done  = 1'b0;
    bus.write_cmd  = '0;
    bus.write_addr = '0;
    bus.read_cmd   = '0;
    bus.read_addr  = '0;

    // ---- reset values
    repeat (3) @(posedge S_CLK);
    #1;
    expect_eq("rst_cmd",  32'(bus.sdram_cmd),  32'(CMD_NOP));
    expect_eq("rst_addr", 32'(bus.sdram_addr), 32'h400);
    expect_eq("rst_busy", 32'(bus.busy),       1);
    expect_eq("rst_wen",  32'(bus.write_en),   0);
    expect_eq("rst_ren",  32'(bus.read_en),    0);
    expect_eq("rst_err",  32'(bus.ack_err),    0);

    // ---- INIT pass-through, init_done on the 10th edge
    RST_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.init_cmd  = 5'(i + 3);
      bus.init_addr = 12'(i * 100 + 7);
      if (i == 9) bus.init_done = 1'b1;
      tick();
      expect_eq("init_cmd",  32'(bus.sdram_cmd),  32'(i + 3));
      expect_eq("init_addr", 32'(bus.sdram_addr), 32'(i * 100 + 7));
      expect_eq("init_busy", 32'(bus.busy),       (i == 9) ? 0 : 1);
    end
    t0 = cyc;
    bus.init_cmd  = 5'h1F;
    bus.init_addr = 12'hFFF;

    // ---- idle refresh: PREC at t0+22, AREF at t0+25, repeating every 20
    for (int k = 1; k <= 45; k++) begin
      tick();
      rel = cyc - t0;
      if (rel >= 22 && rel % 20 == 2)      exp_cmd = CMD_PREC;
      else if (rel >= 25 && rel % 20 == 5) exp_cmd = CMD_AREF;
      else                                 exp_cmd = CMD_NOP;
      expect_eq("ref_cmd",  32'(bus.sdram_cmd),  32'(exp_cmd));
      expect_eq("ref_addr", 32'(bus.sdram_addr), 32'h400);
      expect_eq("ref_busy", 32'(bus.busy),
                32'(rel >= 21 && rel % 20 >= 1 && rel % 20 <= 11));
    end

    // ---- write, ack 7 cycles after write_en, then immediate re-grant
    restart();
    bus.wr_req = 1'b1;
    tick();                                            // t0+1
    expect_eq("wr_grant_wen", 32'(bus.write_en), 1);
    expect_eq("wr_grant_ren", 32'(bus.read_en),  0);
    expect_eq("wr_grant_busy", 32'(bus.busy),    1);
    for (int k = 2; k <= 8; k++) begin
      tick();
      expect_eq("wr1_cmd",  32'(bus.sdram_cmd),  32'(wpat(cyc - 1)));
      expect_eq("wr1_addr", 32'(bus.sdram_addr), 32'(waddr(cyc - 1)));
      expect_eq("wr1_wen",  32'(bus.write_en),   0);
      bus.write_ack = (k == 7);
    end
    expect_eq("wr1_idle_gap", 32'(bus.busy), 0);       // t0+8
    tick();                                            // t0+9
    expect_eq("wr_regrant", 32'(bus.write_en),  1);
    expect_eq("gap_nop",    32'(bus.sdram_cmd), 32'(CMD_NOP));

    // ---- refresh becomes due at t0+20, mid-write; ack at t0+24
    for (int k = 10; k <= 24; k++) begin
      tick();
      expect_eq("wr2_cmd", 32'(bus.sdram_cmd), 32'(wpat(cyc - 1)));
      expect_eq("wr2_wen", 32'(bus.write_en),  0);
      bus.write_ack = (k == 23);
    end
    expect_eq("wr2_done", 32'(bus.busy), 0);           // t0+24
    tick();                                            // t0+25
    expect_eq("ref_before_wr", 32'(bus.write_en), 0);
    expect_eq("ref_busy25",    32'(bus.busy),     1);
    tick();                                            // t0+26
    expect_eq("ref_prec",      32'(bus.sdram_cmd),  32'(CMD_PREC));
    expect_eq("ref_prec_addr", 32'(bus.sdram_addr), 32'h400);
    for (int k = 27; k <= 36; k++) begin
      tick();
      expect_eq("ref2_cmd", 32'(bus.sdram_cmd), (k == 29) ? 32'(CMD_AREF) : 32'(CMD_NOP));
    end
    expect_eq("ref2_idle", 32'(bus.busy), 0);          // t0+36
    tick();                                            // t0+37
    expect_eq("wr_after_ref", 32'(bus.write_en), 1);
    bus.wr_req = 1'b0;
    tick();
    bus.write_ack = 1'b1;
    tick();                                            // t0+39
    bus.write_ack = 1'b0;
    expect_eq("wr3_done", 32'(bus.busy),      0);
    expect_eq("wr3_cmd",  32'(bus.sdram_cmd), 32'(wpat(cyc - 1)));

    // ---- both requesters asserted continuously
    restart();
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    nw = 0;
    nr = 0;
    have_prev = 1'b0;
    prev_w    = 1'b0;
    for (int i = 0; i < 60; i++) begin
      prev_busy = bus.busy;
      tick();
      svc_ack();
      expect_eq("en_excl", 32'(bus.write_en & bus.read_en), 0);
      if (bus.write_en || bus.read_en) begin
        expect_eq("en_from_idle", 32'(prev_busy), 0);
        ack_w  = bus.write_en;
        ack_in = 1;
        if (bus.write_en) nw++;
        else              nr++;
`ifdef ARB_ROUND_ROBIN_EN
        expect_eq("rr_order", 32'(bus.write_en), have_prev ? 32'(!prev_w) : 1);
`else
        expect_eq("fixed_prio", 32'(bus.write_en), 1);
`endif
        prev_w    = bus.write_en;
        have_prev = 1'b1;
      end
    end
    expect_eq("grant_count", 32'(nw + nr >= 5), 1);
`ifdef ARB_ROUND_ROBIN_EN
    expect_eq("rr_balance", 32'(nw - nr <= 1 && nr - nw <= 1), 1);
`else
    expect_eq("no_reads", 32'(nr), 0);
`endif
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      svc_ack();
    end
    expect_eq("drain_noerr", 32'(bus.ack_err), 0);
    expect_eq("drain_idle",  32'(bus.busy),    0);

    // ---- ack withheld: timeout 64 cycles after the grant
    restart();
    bus.wr_req = 1'b1;
    tick();                                            // t0+1
    expect_eq("to_grant", 32'(bus.write_en), 1);
    bus.wr_req = 1'b0;
    for (int k = 2; k <= 64; k++) begin
      tick();
      expect_eq("to_err_early", 32'(bus.ack_err), 0);
    end
    expect_eq("to_busy64", 32'(bus.busy), 1);
    tick();                                            // t0+65
    expect_eq("to_err",  32'(bus.ack_err), 1);
    expect_eq("to_idle", 32'(bus.busy),    0);
    // several wraps were missed while waiting: exactly one refresh owed
    for (int k = 66; k <= 81; k++) begin
      tick();
      if (k == 67)      exp_cmd = CMD_PREC;
      else if (k == 70) exp_cmd = CMD_AREF;
      else              exp_cmd = CMD_NOP;
      expect_eq("to_ref_cmd", 32'(bus.sdram_cmd), 32'(exp_cmd));
    end
    expect_eq("to_err_sticky", 32'(bus.ack_err), 1);

    // ---- read, stray write_ack ignored, then reset mid-read
    restart();
    bus.rd_req = 1'b1;
    tick();                                            // t0+1
    expect_eq("rd_grant_ren", 32'(bus.read_en),  1);
    expect_eq("rd_grant_wen", 32'(bus.write_en), 0);
    bus.rd_req = 1'b0;
    for (int k = 2; k <= 25; k++) begin
      tick();
      expect_eq("rd_cmd",  32'(bus.sdram_cmd),  32'(rpat(cyc - 1)));
      expect_eq("rd_addr", 32'(bus.sdram_addr), 32'(raddr(cyc - 1)));
      expect_eq("rd_busy", 32'(bus.busy),       1);
      bus.write_ack = (k == 10);
    end
    RST_N = 1'b0;
    #1;
    expect_eq("mid_rst_cmd",  32'(bus.sdram_cmd),  32'(CMD_NOP));
    expect_eq("mid_rst_addr", 32'(bus.sdram_addr), 32'h400);
    expect_eq("mid_rst_busy", 32'(bus.busy),       1);
    expect_eq("mid_rst_ren",  32'(bus.read_en),    0);
    tick();
    expect_eq("mid_rst_cmd_edge", 32'(bus.sdram_cmd), 32'(CMD_NOP));
    expect_eq("mid_rst_err_edge", 32'(bus.ack_err),   0);
    RST_N = 1'b1;
    tick();
    t0 = cyc;
    expect_eq("post_rst_idle", 32'(bus.busy), 0);
    // the refresh owed before reset is gone: first PREC only at t0+22
    for (int k = 1; k <= 22; k++) begin
      tick();
      expect_eq("post_rst_cmd", 32'(bus.sdram_cmd), (k == 22) ? 32'(CMD_PREC) : 32'(CMD_NOP));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
